// File: rtl/memory_master.sv
`default_nettype none
// ============================================================================
// memory_master: request/response bridge that issues single-word memory
// accesses and read bursts. Optional MEM_MASTER_RANGE_CHECK_EN adds a window check.
// Revision: 1.0
// ============================================================================
module memory_master #(
  parameter int                    MEMORY_DEPTH = 64,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req_Valid_i,
  output logic                  Req_Ready_o,
  input  logic                  Req_Write_i,
  input  logic [DATA_WIDTH-1:0] Req_Address_i,
  input  logic [DATA_WIDTH-1:0] Req_Data_i,
  input  logic [3:0]            Req_Burst_Len_i,
  output logic [DATA_WIDTH-1:0] Mem_Address_o,
  output logic                  Mem_Write_Enable_o,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i,
  output logic                  Resp_Valid_o,
  input  logic                  Resp_Ready_i,
  output logic [DATA_WIDTH-1:0] Resp_Data_o,
  output logic                  Resp_Last_o,
  output logic                  Resp_Error_o,
  output logic                  Busy_o
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_access = 2'd1;
  localparam logic [1:0] c_resp   = 2'd2;

`ifdef MEM_MASTER_RANGE_CHECK_EN
  localparam bit c_range_check = 1'b1;
`else
  localparam bit c_range_check = 1'b0;
`endif

  // One bit wider than the address so the window end cannot wrap.
  localparam logic [DATA_WIDTH:0] c_window_end =
    {1'b0, BASE_ADDRESS} + {1'b0, DATA_WIDTH'(4 * MEMORY_DEPTH)};

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  write_q, write_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic [4:0]            beats_q, beats_d;
  logic                  w_bad_addr;

  assign w_bad_addr = c_range_check &&
                      (({1'b0, addr_q} < {1'b0, BASE_ADDRESS}) ||
                       ({1'b0, addr_q} >= c_window_end) ||
                       (addr_q[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (reset) state_q <= c_idle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:   if (Req_Valid_i) state_d = c_access;
      c_access: state_d = c_resp;
      c_resp:   if (Resp_Ready_i) state_d = last_q ? c_idle : c_access;
      default:  state_d = c_idle;
    endcase
  end

  always_comb begin
    Req_Ready_o        = (state_q == c_idle);
    Busy_o             = (state_q != c_idle);
    Resp_Valid_o       = (state_q == c_resp);
    Mem_Write_Enable_o = (state_q == c_access) && write_q && !w_bad_addr && !reset;
    Mem_Address_o      = (state_q == c_access) ? addr_q : mem_addr_q;
    Mem_Write_Data_o   = data_q;
    Resp_Data_o        = resp_data_q;
    Resp_Last_o        = last_q;
    Resp_Error_o       = err_q;
  end

  always_comb begin
    addr_d      = addr_q;
    data_d      = data_q;
    write_d     = write_q;
    beats_d     = beats_q;
    mem_addr_d  = mem_addr_q;
    resp_data_d = resp_data_q;
    last_d      = last_q;
    err_d       = err_q;
    case (state_q)
      c_idle: begin
        if (Req_Valid_i) begin
          addr_d  = Req_Address_i;
          data_d  = Req_Data_i;
          write_d = Req_Write_i;
          beats_d = Req_Write_i ? 5'd1 : ({1'b0, Req_Burst_Len_i} + 5'd1);
        end
      end
      c_access: begin
        mem_addr_d  = addr_q;
        resp_data_d = (write_q || w_bad_addr) ? '0 : Mem_Read_Data_i;
        // A rejected address terminates the burst on this beat.
        last_d      = (beats_q == 5'd1) || w_bad_addr;
        err_d       = w_bad_addr;
      end
      c_resp: begin
        if (Resp_Ready_i && !last_q) begin
          addr_d  = addr_q + DATA_WIDTH'(4);
          beats_d = beats_q - 5'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      beats_q     <= '0;
      mem_addr_q  <= '0;
      resp_data_q <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      data_q      <= data_d;
      write_q     <= write_d;
      beats_q     <= beats_d;
      mem_addr_q  <= mem_addr_d;
      resp_data_q <= resp_data_d;
      last_q      <= last_d;
      err_q       <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_master.sv
`default_nettype none
// ============================================================================
// tb_memory_master: randomized transaction-level checking of memory_master.
// Revision: 1.0
// ============================================================================
module tb_memory_master;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic        clk, reset;
  logic        Req_Valid_i, Req_Ready_o, Req_Write_i;
  logic [31:0] Req_Address_i, Req_Data_i;
  logic [3:0]  Req_Burst_Len_i;
  logic [31:0] Mem_Address_o, Mem_Write_Data_o, Mem_Read_Data_i;
  logic        Mem_Write_Enable_o;
  logic        Resp_Valid_o, Resp_Ready_i, Resp_Last_o, Resp_Error_o, Busy_o;
  logic [31:0] Resp_Data_o;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [31:0] seed = 32'h5A5A_1234;
  int          wr_strobes = 0;
  logic [31:0] last_wr_addr = '0, last_wr_data = '0;

  memory_master #(
    .MEMORY_DEPTH(DEPTH),
    .DATA_WIDTH  (32),
    .BASE_ADDRESS(BASE)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .Req_Valid_i       (Req_Valid_i),
    .Req_Ready_o       (Req_Ready_o),
    .Req_Write_i       (Req_Write_i),
    .Req_Address_i     (Req_Address_i),
    .Req_Data_i        (Req_Data_i),
    .Req_Burst_Len_i   (Req_Burst_Len_i),
    .Mem_Address_o     (Mem_Address_o),
    .Mem_Write_Enable_o(Mem_Write_Enable_o),
    .Mem_Write_Data_o  (Mem_Write_Data_o),
    .Mem_Read_Data_i   (Mem_Read_Data_i),
    .Resp_Valid_o      (Resp_Valid_o),
    .Resp_Ready_i      (Resp_Ready_i),
    .Resp_Data_o       (Resp_Data_o),
    .Resp_Last_o       (Resp_Last_o),
    .Resp_Error_o      (Resp_Error_o),
    .Busy_o            (Busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory system: read data is a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ seed;
  endfunction

  assign Mem_Read_Data_i = mem_word(Mem_Address_o);

  function automatic bit ref_bad(input logic [31:0] a);
`ifdef MEM_MASTER_RANGE_CHECK_EN
    longint unsigned au;
    au = a;
    return (au < longint'(BASE)) || (au >= longint'(BASE) + 4 * DEPTH) || (a[1:0] != 2'b00);
`else
    return (a === 32'hx);
`endif
  endfunction

  always @(posedge clk) begin
    if (Mem_Write_Enable_o) begin
      wr_strobes   <= wr_strobes + 1;
      last_wr_addr <= Mem_Address_o;
      last_wr_data <= Mem_Write_Data_o;
    end
  end

  // Issues one request starting at a negedge in IDLE and follows every beat
  // against the transaction model; returns at a negedge in IDLE.
  task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] bl, input int stall);
    int          beats, n, strobes0, exp_strobes;
    logic [31:0] cur, exp_data;
    bit          bad, exp_last;
    beats       = w ? 1 : int'(bl) + 1;
    cur         = a;
    strobes0    = wr_strobes;
    exp_strobes = (w && !ref_bad(a)) ? 1 : 0;
    vectors++;
    if (Req_Ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_idle: got %b want 1", Req_Ready_o);
    end
    Req_Valid_i = 1'b1; Req_Write_i = w; Req_Address_i = a;
    Req_Data_i = d; Req_Burst_Len_i = bl;
    @(negedge clk);
    Req_Valid_i = 1'b0; Req_Address_i = $urandom; Req_Data_i = $urandom;
    Req_Burst_Len_i = 4'($urandom); Req_Write_i = 1'($urandom);
    for (int b = 0; b < beats; b++) begin
      bad = ref_bad(cur);
      vectors++;
      if ({Mem_Address_o, Mem_Write_Enable_o, Resp_Valid_o, Busy_o, Req_Ready_o} !==
          {cur, w && !bad, 1'b0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL access_beat%0d: addr=%h we=%b rv=%b busy=%b rdy=%b want addr=%h we=%b rv=0 busy=1 rdy=0",
                 b, Mem_Address_o, Mem_Write_Enable_o, Resp_Valid_o, Busy_o, Req_Ready_o, cur, w && !bad);
      end
      if (w) begin
        vectors++;
        if (Mem_Write_Data_o !== d) begin
          miscompares++;
          $display("FAIL write_data: got %h want %h", Mem_Write_Data_o, d);
        end
      end
      exp_last = (b == beats - 1) || bad;
      exp_data = (w || bad) ? 32'h0 : mem_word(cur);
      @(negedge clk);
      n = (stall >= 0) ? stall : int'($urandom_range(3, 0));
      for (int s = 0; s <= n; s++) begin
        vectors++;
        if ({Resp_Valid_o, Resp_Last_o, Resp_Error_o, Resp_Data_o, Req_Ready_o} !==
            {1'b1, exp_last, bad, exp_data, 1'b0}) begin
          miscompares++;
          $display("FAIL resp_beat%0d_cyc%0d: rv=%b last=%b err=%b data=%h rdy=%b want rv=1 last=%b err=%b data=%h rdy=0",
                   b, s, Resp_Valid_o, Resp_Last_o, Resp_Error_o, Resp_Data_o, Req_Ready_o,
                   exp_last, bad, exp_data);
        end
        Resp_Ready_i = (s == n);
        @(negedge clk);
      end
      Resp_Ready_i = 1'b0;
      if (exp_last) break;
      cur = cur + 32'd4;
    end
    vectors++;
    if ({Req_Ready_o, Busy_o, Resp_Valid_o, Mem_Write_Enable_o, Mem_Address_o} !==
        {1'b1, 1'b0, 1'b0, 1'b0, cur}) begin
      miscompares++;
      $display("FAIL idle_after: rdy=%b busy=%b rv=%b we=%b addr=%h want 1 0 0 0 addr=%h",
               Req_Ready_o, Busy_o, Resp_Valid_o, Mem_Write_Enable_o, Mem_Address_o, cur);
    end
    vectors++;
    if (wr_strobes - strobes0 !== exp_strobes) begin
      miscompares++;
      $display("FAIL write_strobes: got %0d want %0d", wr_strobes - strobes0, exp_strobes);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; Req_Valid_i = 1'b0; Req_Write_i = 1'b0; Req_Address_i = '0;
    Req_Data_i = '0; Req_Burst_Len_i = '0; Resp_Ready_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({Req_Ready_o, Resp_Valid_o, Resp_Last_o, Resp_Error_o, Mem_Write_Enable_o, Busy_o,
         Resp_Data_o, Mem_Address_o, Mem_Write_Data_o} !== {6'b100000, 96'h0}) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b rv=%b last=%b err=%b we=%b busy=%b data=%h addr=%h wd=%h want rdy=1 rest 0",
               Req_Ready_o, Resp_Valid_o, Resp_Last_o, Resp_Error_o, Mem_Write_Enable_o, Busy_o,
               Resp_Data_o, Mem_Address_o, Mem_Write_Data_o);
    end
  endtask

  task automatic test_write;
    run_txn(1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 4'hF, 0);
    vectors++;
    if ({last_wr_addr, last_wr_data} !== {32'h1001_0008, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL write_target: addr=%h data=%h want 10010008 deadbeef", last_wr_addr, last_wr_data);
    end
  endtask

  task automatic test_read_burst;
    run_txn(1'b0, BASE, 32'h0, 4'd3, 0);
  endtask

  task automatic test_backpressure;
    run_txn(1'b0, BASE + 32'h20, 32'h0, 4'd0, 5);
  endtask

  task automatic test_wrap;
    run_txn(1'b0, 32'hFFFF_FFFC, 32'h0, 4'd1, 0);
  endtask

  task automatic test_range_edges;
    run_txn(1'b0, BASE + 32'd248, 32'h0, 4'd2, 0);
    run_txn(1'b1, 32'h1001_0002, 32'h1234_5678, 4'd0, 0);
    run_txn(1'b1, BASE + 32'd252, 32'hCAFE_F00D, 4'd0, 1);
  endtask

  task automatic test_reset_in_access;
    int strobes0;
    Req_Valid_i = 1'b1; Req_Write_i = 1'b1; Req_Address_i = BASE + 32'h10;
    Req_Data_i = 32'hA5A5_A5A5; Req_Burst_Len_i = '0;
    @(negedge clk);
    Req_Valid_i = 1'b0;
    strobes0 = wr_strobes;
    vectors++;
    if (Mem_Write_Enable_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_access_pre_we: got %b want 1", Mem_Write_Enable_o);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (Mem_Write_Enable_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_access_we_gated: got %b want 0", Mem_Write_Enable_o);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({Busy_o, Req_Ready_o, Resp_Valid_o} !== 3'b010) begin
        miscompares++;
        $display("FAIL rst_access_idle%0d: busy=%b rdy=%b rv=%b want 0 1 0", i, Busy_o, Req_Ready_o, Resp_Valid_o);
      end
      @(negedge clk);
    end
    vectors++;
    if (wr_strobes !== strobes0) begin
      miscompares++;
      $display("FAIL rst_access_strobes: got %0d want %0d", wr_strobes, strobes0);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      if ($urandom_range(7, 0) == 0) a = $urandom;
      else a = BASE + 32'(4 * $urandom_range(DEPTH - 1, 0));
      run_txn(1'($urandom), a, $urandom, 4'($urandom), -1);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read_burst;
    test_backpressure;
    test_wrap;
    test_range_edges;
    test_reset_in_access;
    seed = $urandom;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
